// File: rtl/bufid_allocate.sv
// Packet buffer ID allocator: pops free IDs, keeps one prefetched,
// and grants them round-robin to input ports with a low-watermark rule.
module bufid_allocate #(
  parameter int PORT_NUM      = 9,
  parameter int LOW_WATERMARK = 16
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                i_hardware_initial_finish,
  output logic                o_fifo_rd,
  input  logic [8:0]          iv_fifo_rdata,
  input  logic                i_fifo_empty,
  input  logic                i_free_bufid_wr,
  input  logic [PORT_NUM-1:0] iv_bufid_req,
  input  logic [PORT_NUM-1:0] iv_prio_port_mask,
  output logic [PORT_NUM-1:0] ov_bufid_ack,
  output logic [8:0]          ov_bufid,
  output logic [9:0]          ov_free_bufid_cnt,
  output logic                o_bufid_low,
  output logic [2:0]          ov_bufid_alloc_state
);

  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam logic [9:0] CNT_MAX = 10'd511;

  typedef enum logic [2:0] {
    INIT_S  = 3'd0,
    FETCH_S = 3'd1,
    RD_S    = 3'd2,
    LOAD_S  = 3'd3,
    GRANT_S = 3'd4
  } state_t;

  state_t        r_state;
  logic [8:0]    r_pf_id;
  logic          r_pf_valid;
  logic [PW-1:0] r_rr;

  logic [PORT_NUM-1:0] w_elig;
  logic [PORT_NUM-1:0] w_onehot;
  logic                w_hit;
  logic [PW-1:0]       w_sel;
  logic [PW-1:0]       w_rr_nxt;
  logic                w_grant;
  logic [9:0]          w_cnt_nxt;
  int                  w_j;

  // below the watermark only priority ports are allowed to compete
  assign w_elig = iv_bufid_req &
                  ({PORT_NUM{~o_bufid_low}} | iv_prio_port_mask);

  // first eligible port at or after the round-robin pointer
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_j   = 0;
    for (int k = 0; k < PORT_NUM; k++) begin
      w_j = int'(r_rr) + k;
      if (w_j >= PORT_NUM) w_j = w_j - PORT_NUM;
      if (!w_hit && w_elig[PW'(w_j)]) begin
        w_hit = 1'b1;
        w_sel = PW'(w_j);
      end
    end
  end

  assign w_rr_nxt = (w_sel == PW'(PORT_NUM - 1)) ?
                    '0 : w_sel + PW'(1);
  assign w_onehot = {{(PORT_NUM-1){1'b0}}, 1'b1} << w_sel;
  assign w_grant  = (r_state == GRANT_S) && r_pf_valid && w_hit;

  // saturating free count: recycle adds one, grant takes one
  always_comb begin
    w_cnt_nxt = ov_free_bufid_cnt;
    if (i_free_bufid_wr && !w_grant) begin
      if (ov_free_bufid_cnt != CNT_MAX)
        w_cnt_nxt = ov_free_bufid_cnt + 10'd1;
    end else if (w_grant && !i_free_bufid_wr) begin
      if (ov_free_bufid_cnt != 10'd0)
        w_cnt_nxt = ov_free_bufid_cnt - 10'd1;
    end
  end

  // register the count and the low flag derived from it
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ov_free_bufid_cnt <= '0;
      o_bufid_low       <= 1'b1;
    end else begin
      ov_free_bufid_cnt <= w_cnt_nxt;
      o_bufid_low       <= (w_cnt_nxt < 10'(LOW_WATERMARK));
    end
  end

  // fetch/prefetch/grant sequencer with registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= INIT_S;
      o_fifo_rd    <= 1'b0;
      ov_bufid_ack <= '0;
      ov_bufid     <= '0;
      r_pf_id      <= '0;
      r_pf_valid   <= 1'b0;
      r_rr         <= '0;
    end else begin
      ov_bufid_ack <= '0;
      unique case (r_state)
        INIT_S: begin
          if (i_hardware_initial_finish) r_state <= FETCH_S;
        end
        FETCH_S: begin
          if (!i_fifo_empty) begin
            o_fifo_rd <= 1'b1;
            r_state   <= RD_S;
          end
        end
        RD_S: begin
          o_fifo_rd <= 1'b0;
          r_state   <= LOAD_S;
        end
        LOAD_S: begin
          r_pf_id    <= iv_fifo_rdata;
          r_pf_valid <= 1'b1;
          r_state    <= GRANT_S;
        end
        GRANT_S: begin
          if (w_grant) begin
            ov_bufid_ack <= w_onehot;
            ov_bufid     <= r_pf_id;
            r_pf_valid   <= 1'b0;
            r_rr         <= w_rr_nxt;
            r_state      <= FETCH_S;
          end
        end
        default: r_state <= INIT_S;
      endcase
    end
  end

  assign ov_bufid_alloc_state = r_state;

endmodule

// File: tb/tb_bufid_allocate.sv
// Bench for bufid_allocate: free FIFO model, table-driven arbitration
// vectors, random traffic against a queue-based reference model.
module tb_bufid_allocate;

  localparam int PN = 9;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       i_hardware_initial_finish = 1'b0;
  logic       o_fifo_rd;
  logic [8:0] iv_fifo_rdata = '0;
  logic       i_fifo_empty = 1'b1;
  logic       i_free_bufid_wr = 1'b0;
  logic [8:0] wdata = '0;
  logic [8:0] iv_bufid_req = '0;
  logic [8:0] iv_prio_port_mask = '0;
  logic [8:0] ov_bufid_ack;
  logic [8:0] ov_bufid;
  logic [9:0] cnt_o;
  logic       o_bufid_low;
  logic [2:0] st_o;

  bufid_allocate #(.PORT_NUM(PN), .LOW_WATERMARK(16)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .i_hardware_initial_finish(i_hardware_initial_finish),
    .o_fifo_rd(o_fifo_rd),
    .iv_fifo_rdata(iv_fifo_rdata),
    .i_fifo_empty(i_fifo_empty),
    .i_free_bufid_wr(i_free_bufid_wr),
    .iv_bufid_req(iv_bufid_req),
    .iv_prio_port_mask(iv_prio_port_mask),
    .ov_bufid_ack(ov_bufid_ack),
    .ov_bufid(ov_bufid),
    .ov_free_bufid_cnt(cnt_o),
    .o_bufid_low(o_bufid_low),
    .ov_bufid_alloc_state(st_o)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // free FIFO: normal mode, data valid the cycle after the read strobe
  logic [8:0] fq[$];
  always @(posedge clk_sys) begin
    if (o_fifo_rd === 1'b1) begin
      chk("fifo_underflow", int'(fq.size() > 0), 1);
      if (fq.size() > 0) iv_fifo_rdata <= fq.pop_front();
    end
    if (i_free_bufid_wr) fq.push_back(wdata);
    i_fifo_empty <= (fq.size() == 0);
  end

  // reference model: ID order, saturating count, RR pointer
  int         mcnt = 0;
  bit         mlow = 1'b1;
  int         mrr = 0;
  logic [8:0] mq[$];
  int         cyc = 0;
  int         last_ack = -100;
  int         last_bufid = 0;
  bit         mon_en = 1'b0;

  function automatic int exp_port(input logic [8:0] req,
                                  input logic [8:0] pr,
                                  input bit low, input int rr);
    for (int k = 0; k < PN; k++) begin
      int j = (rr + k) % PN;
      if (req[j] && (!low || pr[j])) return j;
    end
    return 99;
  endfunction

  task automatic model_check();
    int dec;
    int gp;
    int e;
    dec = 0;
    if (ov_bufid_ack != 0) begin
      chk("ack_onehot", $countones(ov_bufid_ack), 1);
      gp = 99;
      for (int i = PN - 1; i >= 0; i--) if (ov_bufid_ack[i]) gp = i;
      chk("ack_port", gp,
          exp_port(iv_bufid_req, iv_prio_port_mask, mlow, mrr));
      chk("ack_gap", int'(cyc - last_ack >= 4), 1);
      e = (mq.size() > 0) ? int'(mq.pop_front()) : -1;
      chk("ack_id", int'(ov_bufid), e);
      last_bufid = e;
      last_ack = cyc;
      mrr = (gp + 1) % PN;
      dec = 1;
    end else begin
      chk("bufid_hold", int'(ov_bufid), last_bufid);
    end
    if (i_free_bufid_wr) mq.push_back(wdata);
    if (i_free_bufid_wr && dec == 0) begin
      if (mcnt < 511) mcnt++;
    end else if (dec == 1 && !i_free_bufid_wr) begin
      if (mcnt > 0) mcnt--;
    end
    mlow = (mcnt < 16);
    chk("cnt", int'(cnt_o), mcnt);
    chk("low", int'(o_bufid_low), int'(mlow));
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
    if (mon_en) model_check();
  endtask

  task automatic wait_ack(input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      step();
      n++;
      if (ov_bufid_ack != 0) return;
    end
    chk("ack_timeout", int'(ov_bufid_ack != 0), 1);
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (st_o == s) break;
      step();
    end
    chk("wait_state", int'(st_o), int'(s));
  endtask

  typedef struct {
    logic [8:0] req;
    int         port;
    int         id;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;

    tbl[0]  = '{9'h1FF, 6, 11};
    tbl[1]  = '{9'h1FF, 7, 12};
    tbl[2]  = '{9'h1FF, 8, 13};
    tbl[3]  = '{9'h1FF, 0, 14};
    tbl[4]  = '{9'h1FF, 1, 15};
    tbl[5]  = '{9'h1FF, 2, 16};
    tbl[6]  = '{9'h1FF, 3, 17};
    tbl[7]  = '{9'h1FF, 4, 18};
    tbl[8]  = '{9'h1FF, 5, 19};
    tbl[9]  = '{9'h1FF, 6, 20};
    tbl[10] = '{9'h081, 7, 21};
    tbl[11] = '{9'h081, 0, 22};
    tbl[12] = '{9'h081, 7, 23};
    tbl[13] = '{9'h100, 8, 24};
    tbl[14] = '{9'h030, 4, 25};
    tbl[15] = '{9'h030, 5, 26};
    tbl[16] = '{9'h030, 4, 27};
    tbl[17] = '{9'h003, 0, 28};
    tbl[18] = '{9'h003, 1, 29};

    // reset values
    step();
    step();
    chk("rst_rd", int'(o_fifo_rd), 0);
    chk("rst_ack", int'(ov_bufid_ack), 0);
    chk("rst_bufid", int'(ov_bufid), 0);
    chk("rst_cnt", int'(cnt_o), 0);
    chk("rst_low", int'(o_bufid_low), 1);
    chk("rst_state", int'(st_o), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // initial fill: IDs 9..511
    for (int i = 9; i <= 511; i++) begin
      i_free_bufid_wr = 1'b1;
      wdata = 9'(i);
      step();
    end
    i_free_bufid_wr = 1'b0;
    chk("init_cnt", int'(cnt_o), 503);
    chk("init_low", int'(o_bufid_low), 0);
    chk("init_hold_state", int'(st_o), 0);

    // nine more writes push the count into saturation at 511
    for (int i = 0; i < 9; i++) begin
      i_free_bufid_wr = 1'b1;
      wdata = 9'(i);
      step();
    end
    i_free_bufid_wr = 1'b0;
    chk("sat_hi_cnt", int'(cnt_o), 511);

    i_hardware_initial_finish = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_fifo_rd) pulses++;
      if (st_o == 3'd4) break;
    end
    i_hardware_initial_finish = 1'b0;
    chk("init_rd_pulses", pulses, 1);
    chk("init_grant_state", int'(st_o), 4);

    // single request, then a second grant exactly 4 cycles later
    iv_bufid_req = 9'h004;
    step();
    chk("single_ack", int'(ov_bufid_ack), 9'h004);
    chk("single_id", int'(ov_bufid), 9);
    chk("single_cnt", int'(cnt_o), 510);
    iv_bufid_req = 9'h020;
    wait_ack(8, n);
    chk("regrant_gap", n, 4);
    chk("regrant_ack", int'(ov_bufid_ack), 9'h020);
    chk("regrant_id", int'(ov_bufid), 10);
    iv_bufid_req = '0;

    // round-robin vectors
    for (int i = 0; i < 19; i++) begin
      iv_bufid_req = tbl[i].req;
      wait_ack(12, n);
      chk("tbl_ack", int'(ov_bufid_ack), 1 << tbl[i].port);
      chk("tbl_id", int'(ov_bufid), tbl[i].id);
    end
    iv_bufid_req = '0;

    // random traffic draining the pool
    for (int i = 0; i < 8000 && mcnt > 30; i++) begin
      iv_bufid_req = 9'($urandom);
      iv_prio_port_mask = 9'($urandom);
      i_free_bufid_wr = ($urandom_range(0, 31) == 0);
      wdata = 9'($urandom);
      step();
    end
    i_free_bufid_wr = 1'b0;
    chk("rand_drained", int'(mcnt <= 30), 1);

    // watermark: below 16 only the priority port is served
    iv_prio_port_mask = 9'h001;
    iv_bufid_req = 9'h1FF;
    for (int i = 0; i < 400 && mcnt > 15; i++) step();
    chk("wm_cnt15", int'(cnt_o), 15);
    chk("wm_low", int'(o_bufid_low), 1);
    wait_ack(8, n);
    chk("wm_prio_ack", int'(ov_bufid_ack), 9'h001);
    i_free_bufid_wr = 1'b1;
    wdata = 9'd300;
    step();
    wdata = 9'd301;
    step();
    i_free_bufid_wr = 1'b0;
    chk("wm_cnt16", int'(cnt_o), 16);
    chk("wm_low0", int'(o_bufid_low), 0);
    wait_ack(8, n);
    chk("wm_rr_ack", int'(ov_bufid_ack), 9'h002);

    // grant coinciding with a recycle write leaves the count unchanged
    iv_prio_port_mask = 9'h1FF;
    wait_state(3'd4, 8);
    i_free_bufid_wr = 1'b1;
    wdata = 9'd302;
    step();
    i_free_bufid_wr = 1'b0;
    chk("sim_ack", int'(ov_bufid_ack != 0), 1);
    chk("sim_cnt", int'(cnt_o), 15);

    // drain every ID; count bottoms out at 0
    for (int i = 0; i < 4000 && mq.size() > 0; i++) step();
    chk("drain_empty", mq.size(), 0);
    iv_bufid_req = 9'h008;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("empty_no_ack", int'(ov_bufid_ack), 0);
    end
    chk("empty_state", int'(st_o), 1);
    chk("empty_cnt", int'(cnt_o), 0);
    i_free_bufid_wr = 1'b1;
    wdata = 9'd77;
    step();
    i_free_bufid_wr = 1'b0;
    wait_ack(4, n);
    chk("refill_ack", int'(ov_bufid_ack), 9'h008);
    chk("refill_id", int'(ov_bufid), 77);
    iv_bufid_req = '0;

    // reset while the read strobe is up
    i_free_bufid_wr = 1'b1;
    wdata = 9'd78;
    step();
    i_free_bufid_wr = 1'b0;
    wait_state(3'd2, 8);
    reset = 1'b1;
    mon_en = 1'b0;
    step();
    chk("rd_rst_rd", int'(o_fifo_rd), 0);
    chk("rd_rst_ack", int'(ov_bufid_ack), 0);
    chk("rd_rst_bufid", int'(ov_bufid), 0);
    chk("rd_rst_cnt", int'(cnt_o), 0);
    chk("rd_rst_low", int'(o_bufid_low), 1);
    chk("rd_rst_state", int'(st_o), 0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
